// File: rtl/mcode_pkg.sv
// mcode_pkg: table selects, sizes and the loader state type shared by the
// microcode loader and the decode stage.
// Optional feature macro: MICROCODE_LOADER_CHECKSUM_EN (adds the CSUM state).
package mcode_pkg;

   localparam int CS_W         = 64;
   localparam int CTRL_DEPTH   = 64;
   localparam int REGIMM_DEPTH = 32;

   localparam logic [1:0] TBL_CONTROL = 2'd0;
   localparam logic [1:0] TBL_ALUFUNC = 2'd1;
   localparam logic [1:0] TBL_REGIMM  = 2'd2;
   localparam logic [1:0] TBL_INVALID = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_COUNT = 3'd1,
      ST_DATA  = 3'd2,
      ST_WRITE = 3'd3,
      ST_ERROR = 3'd4
`ifdef MICROCODE_LOADER_CHECKSUM_EN
      , ST_CSUM = 3'd5
`endif
   } state_t;

   // Next table index, wrapping back to entry 0 after the table's last entry.
   function automatic logic [5:0] next_addr(input logic [5:0] addr, input logic [5:0] last);
      logic [5:0] nxt;
      if (addr == last) begin
         nxt = 6'd0;
      end else begin
         nxt = addr + 6'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/microcode_loader_if.sv
// microcode_loader_if: byte-stream input handshake plus the 64-bit table
// write port. master = the loader, slave = the byte source / RAM side.
interface microcode_loader_if #(
   parameter int CS_W = mcode_pkg::CS_W
) ();
   logic            in_valid;
   logic            in_ready;
   logic [7:0]      in_data;
   logic            wr_en;
   logic [1:0]      wr_table;
   logic [5:0]      wr_addr;
   logic [CS_W-1:0] wr_data;

   modport master (
      input  in_valid,
      input  in_data,
      output in_ready,
      output wr_en,
      output wr_table,
      output wr_addr,
      output wr_data
   );

   modport slave (
      output in_valid,
      output in_data,
      input  in_ready,
      input  wr_en,
      input  wr_table,
      input  wr_addr,
      input  wr_data
   );
endinterface

// File: rtl/mcode_word_assembler.sv
// mcode_word_assembler: little-endian byte-to-word shift register. The first
// byte of a word ends up in bits [7:0]. 'word' is the word including the byte
// currently offered, so it is complete in the cycle word_ready is high.
module mcode_word_assembler
   import mcode_pkg::*;
#(
   parameter int CS_W = mcode_pkg::CS_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            shift_en,
   input  logic [7:0]      byte_in,
   output logic [CS_W-1:0] word,
   output logic            word_ready
);
   localparam int BYTES = CS_W / 8;
   localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);

   logic [CS_W-1:0]  shift_r;
   logic [CNT_W-1:0] cnt_r;

   assign word       = {byte_in, shift_r[CS_W-1:8]};
   assign word_ready = shift_en && (cnt_r == CNT_LAST);

   // Shift accepted bytes in from the top and count bytes within the word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_r <= '0;
         cnt_r   <= '0;
      end else if (clr) begin
         shift_r <= '0;
         cnt_r   <= '0;
      end else if (shift_en) begin
         shift_r <= word;
         cnt_r   <= (cnt_r == CNT_LAST) ? '0 : cnt_r + CNT_W'(1);
      end else begin
         shift_r <= shift_r;
         cnt_r   <= cnt_r;
      end
   end
endmodule

// File: rtl/microcode_loader.sv
// microcode_loader: parses HDR / CNT / payload frames from a byte stream and
// issues one-cycle table writes into the control, alufunc and regimm tables.
// Optional feature macro: MICROCODE_LOADER_CHECKSUM_EN -- each frame ends with
// an XOR checksum byte over HDR, CNT and payload.
module microcode_loader
   import mcode_pkg::*;
#(
   parameter int CS_W         = mcode_pkg::CS_W,
   parameter int CTRL_DEPTH   = mcode_pkg::CTRL_DEPTH,
   parameter int REGIMM_DEPTH = mcode_pkg::REGIMM_DEPTH
) (
   input  logic               clk,
   input  logic               rst_n,
   microcode_loader_if.master bus,
   output logic               busy,
   output logic               done,
   output logic               err,
   input  logic               err_clear
);
   localparam logic [6:0] REGIMM_LIM  = 7'(REGIMM_DEPTH);
   localparam logic [5:0] CTRL_LAST   = 6'(CTRL_DEPTH - 1);
   localparam logic [5:0] REGIMM_LAST = 6'(REGIMM_DEPTH - 1);

   state_t          state_r;
   logic [1:0]      tbl_r;
   logic [5:0]      addr_r;
   logic [7:0]      remain_r;
   logic            in_ready_r;
   logic            wr_en_r;
   logic [1:0]      wr_table_r;
   logic [5:0]      wr_addr_r;
   logic [CS_W-1:0] wr_data_r;
   logic            busy_r;
   logic            done_r;
   logic            err_r;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
   logic [7:0]      csum_r;
`endif

   logic            accept_s;
   logic [1:0]      hdr_tbl_s;
   logic [5:0]      hdr_addr_s;
   logic            hdr_bad_s;
   logic [5:0]      last_addr_s;
   logic [CS_W-1:0] asm_word_s;
   logic            word_ready_s;

   assign accept_s   = bus.in_valid && in_ready_r;
   assign hdr_tbl_s  = bus.in_data[7:6];
   assign hdr_addr_s = bus.in_data[5:0];
   assign hdr_bad_s  = (hdr_tbl_s == TBL_INVALID) ||
                       ((hdr_tbl_s == TBL_REGIMM) && ({1'b0, hdr_addr_s} >= REGIMM_LIM));

   // Last valid index of the table selected by the current frame.
   always_comb begin
      last_addr_s = CTRL_LAST;
      case (tbl_r)
         TBL_CONTROL: last_addr_s = CTRL_LAST;
         TBL_ALUFUNC: last_addr_s = CTRL_LAST;
         TBL_REGIMM:  last_addr_s = REGIMM_LAST;
         default:     last_addr_s = CTRL_LAST;
      endcase
   end

   mcode_word_assembler #(.CS_W(CS_W)) u_asm (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (state_r == ST_IDLE),
      .shift_en   (accept_s && (state_r == ST_DATA)),
      .byte_in    (bus.in_data),
      .word       (asm_word_s),
      .word_ready (word_ready_s)
   );

   // Frame parser: state plus registered handshake, write-port and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         tbl_r      <= 2'd0;
         addr_r     <= 6'd0;
         remain_r   <= 8'd0;
         in_ready_r <= 1'b0;
         wr_en_r    <= 1'b0;
         wr_table_r <= 2'd0;
         wr_addr_r  <= 6'd0;
         wr_data_r  <= '0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
         csum_r     <= 8'd0;
`endif
      end else begin
         // wr_en and done are single-cycle pulses
         wr_en_r <= 1'b0;
         done_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               in_ready_r <= 1'b1;
               if (accept_s) begin
                  tbl_r  <= hdr_tbl_s;
                  addr_r <= hdr_addr_s;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
                  csum_r <= bus.in_data;
`endif
                  if (hdr_bad_s) begin
                     state_r    <= ST_ERROR;
                     in_ready_r <= 1'b0;
                     err_r      <= 1'b1;
                     busy_r     <= 1'b0;
                  end else begin
                     state_r <= ST_COUNT;
                     busy_r  <= 1'b1;
                  end
               end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            ST_COUNT: begin
               if (accept_s) begin
                  remain_r <= bus.in_data;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
                  csum_r   <= csum_r ^ bus.in_data;
`endif
                  if (bus.in_data == 8'd0) begin
`ifdef MICROCODE_LOADER_CHECKSUM_EN
                     state_r <= ST_CSUM;
`else
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
`endif
                  end else begin
                     state_r <= ST_DATA;
                  end
               end else begin
                  state_r <= ST_COUNT;
               end
            end
            ST_DATA: begin
               if (accept_s) begin
`ifdef MICROCODE_LOADER_CHECKSUM_EN
                  csum_r <= csum_r ^ bus.in_data;
`endif
                  if (word_ready_s) begin
                     state_r    <= ST_WRITE;
                     in_ready_r <= 1'b0;
                     wr_en_r    <= 1'b1;
                     wr_table_r <= tbl_r;
                     wr_addr_r  <= addr_r;
                     wr_data_r  <= asm_word_s;
`ifndef MICROCODE_LOADER_CHECKSUM_EN
                     // final word: done coincides with its write strobe
                     done_r     <= (remain_r == 8'd1);
`endif
                  end else begin
                     state_r <= ST_DATA;
                  end
               end else begin
                  state_r <= ST_DATA;
               end
            end
            ST_WRITE: begin
               addr_r     <= next_addr(addr_r, last_addr_s);
               remain_r   <= remain_r - 8'd1;
               in_ready_r <= 1'b1;
               if (remain_r == 8'd1) begin
`ifdef MICROCODE_LOADER_CHECKSUM_EN
                  state_r <= ST_CSUM;
`else
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
`endif
               end else begin
                  state_r <= ST_DATA;
               end
            end
            ST_ERROR: begin
               if (err_clear) begin
                  state_r    <= ST_IDLE;
                  in_ready_r <= 1'b1;
                  err_r      <= 1'b0;
               end else begin
                  state_r    <= ST_ERROR;
                  in_ready_r <= 1'b0;
                  err_r      <= 1'b1;
               end
            end
`ifdef MICROCODE_LOADER_CHECKSUM_EN
            ST_CSUM: begin
               if (accept_s) begin
                  busy_r <= 1'b0;
                  if (bus.in_data == csum_r) begin
                     state_r <= ST_IDLE;
                     done_r  <= 1'b1;
                  end else begin
                     state_r    <= ST_ERROR;
                     in_ready_r <= 1'b0;
                     err_r      <= 1'b1;
                  end
               end else begin
                  state_r <= ST_CSUM;
               end
            end
`endif
            default: begin
               state_r    <= ST_ERROR;
               in_ready_r <= 1'b0;
               err_r      <= 1'b1;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready = in_ready_r;
   assign bus.wr_en    = wr_en_r;
   assign bus.wr_table = wr_table_r;
   assign bus.wr_addr  = wr_addr_r;
   assign bus.wr_data  = wr_data_r;
   assign busy         = busy_r;
   assign done         = done_r;
   assign err          = err_r;
endmodule
